// File: rtl/muldiv_sequencer_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer and its datapath.
// Also extends the decoder control word with the flag that launches a mul/div.
package muldiv_sequencer_pkg;

    localparam int MULDIV_XLEN    = 32;
    localparam int MULDIV_LATENCY = MULDIV_XLEN + 1;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } muldiv_state_type;

    typedef struct packed {
        logic          reg_write;
        logic          mem_read;
        logic          mem_write;
        logic          is_muldiv;
        muldiv_op_type muldiv_op;
    } control_type;

    function automatic logic is_div_op(input muldiv_op_type op);
        return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
    endfunction

endpackage

// File: rtl/muldiv_sequencer_datapath.sv
// Shared accumulator/shift pair: shift-add multiply or restoring divide, one bit per step.
// result_calc reflects the value after the current step, so the last step's result can be registered directly.
module muldiv_sequencer_datapath
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic [XLEN-1:0] result_calc
);

    muldiv_op_type   op_in;
    muldiv_op_type   op_q;
    logic [XLEN-1:0] acc, mq, mcand;
    logic            neg_hi, neg_lo;

    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic [XLEN-1:0] acc_nxt, mq_nxt;
    logic [XLEN:0]   sum, shifted, diff;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quot_s, rem_s;

    assign op_in = muldiv_op_type'(op);

    always_comb begin
        a_signed = (op_in == MUL) || (op_in == MULH) || (op_in == MULHSU) ||
                   (op_in == DIV) || (op_in == REM);
        b_signed = (op_in == MUL) || (op_in == MULH) || (op_in == DIV) || (op_in == REM);
        a_neg    = a_signed & operand_a[XLEN-1];
        b_neg    = b_signed & operand_b[XLEN-1];
        mag_a    = a_neg ? -operand_a : operand_a;
        mag_b    = b_neg ? -operand_b : operand_b;
    end

    // Multiply consumes mq LSB-first; divide shifts dividend bits out of mq MSB-first
    // while quotient bits shift in at the bottom.
    always_comb begin
        sum     = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : {(XLEN+1){1'b0}});
        shifted = {acc, mq[XLEN-1]};
        diff    = shifted - {1'b0, mcand};
        acc_nxt = acc;
        mq_nxt  = mq;
        if (is_div_op(op_q)) begin
            if (!diff[XLEN]) begin
                acc_nxt = diff[XLEN-1:0];
                mq_nxt  = {mq[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[XLEN-1:0];
                mq_nxt  = {mq[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = sum[XLEN:1];
            mq_nxt  = {sum[0], mq[XLEN-1:1]};
        end
    end

    always_comb begin
        prod   = {acc_nxt, mq_nxt};
        prod_s = neg_hi ? -prod : prod;
        quot_s = neg_hi ? -mq_nxt : mq_nxt;
        rem_s  = neg_lo ? -acc_nxt : acc_nxt;
        case (op_q)
            MUL:         result_calc = prod_s[XLEN-1:0];
            DIV, DIVU:   result_calc = quot_s;
            REM, REMU:   result_calc = rem_s;
            default:     result_calc = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            mq     <= '0;
            mcand  <= '0;
            op_q   <= MUL;
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mq     <= mag_a;
            mcand  <= mag_b;
            op_q   <= op_in;
            neg_hi <= a_neg ^ b_neg;
            neg_lo <= a_neg;
        end else if (step) begin
            acc    <= acc_nxt;
            mq     <= mq_nxt;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: stalls EX for XLEN+1 cycles, then a one-cycle done with registered result.
// Divide-by-zero and signed overflow finish in one cycle; MULDIV_ZERO_BYPASS_EN also short-cuts zero multiplies.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_type state, state_nxt;
    muldiv_op_type    op_t;
    logic [CNT_W-1:0] cnt;
    logic             last_iter, accept, load, step;
    logic             div_zero, div_ovf, zero_mul, special;
    logic [XLEN-1:0]  special_res, result_calc;

    assign op_t      = muldiv_op_type'(op);
    assign last_iter = (cnt == CNT_W'(XLEN-1));
    assign accept    = (state == IDLE) && start && !flush;

    always_comb begin
        div_zero = is_div_op(op_t) && (operand_b == '0);
        div_ovf  = ((op_t == DIV) || (op_t == REM)) &&
                   (operand_a == {1'b1, {(XLEN-1){1'b0}}}) && (operand_b == '1);
`ifdef MULDIV_ZERO_BYPASS_EN
        zero_mul = !is_div_op(op_t) && ((operand_a == '0) || (operand_b == '0));
`else
        zero_mul = 1'b0;
`endif
        special     = div_zero || div_ovf || zero_mul;
        special_res = '0;
        if (div_zero)
            special_res = ((op_t == DIV) || (op_t == DIVU)) ? '1 : operand_a;
        else if (div_ovf)
            special_res = (op_t == DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = special ? DONE : CALC;
            CALC:    if (flush) state_nxt = IDLE;
                     else if (last_iter) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        stall = accept || (state == CALC);
        done  = (state == DONE) && !flush;
        load  = accept;
        step  = (state == CALC);
    end

    always_ff @(posedge clk) begin
        if (reset || (state != CALC))
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // Result is captured on entry to DONE and held until the next completion.
    always_ff @(posedge clk) begin
        if (reset)
            result <= '0;
        else if (accept && special)
            result <= special_res;
        else if ((state == CALC) && !flush && last_iter)
            result <= result_calc;
    end

    muldiv_sequencer_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .step       (step),
        .op         (op),
        .operand_a  (operand_a),
        .operand_b  (operand_b),
        .result_calc(result_calc)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vector table, multi-cycle flush/reset sequences,
// and random operations checked against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_sequencer_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset, start, flush;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a, operand_b;
    logic            stall, busy, done;
    logic [XLEN-1:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .flush    (flush),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          exp_lat;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic signed [63:0] sa64, sb64, sp;
        logic [63:0]        up;
        logic signed [31:0] sa, sb, sq;
        logic [31:0]        r;
        sa = a;
        sb = b;
        r  = '0;
        case (o)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
            3'd1: begin sa64 = {{32{a[31]}}, a}; sb64 = {{32{b[31]}}, b};
                        sp = sa64 * sb64; r = sp[63:32]; end
            3'd2: begin sa64 = {{32{a[31]}}, a}; sb64 = {32'b0, b};
                        sp = sa64 * sb64; r = sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
            3'd4: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h8000_0000;
                else begin sq = sa / sb; r = sq; end
            end
            3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'h0;
                else begin sq = sa % sb; r = sq; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o >= 3'd4 && b == 0) return 1;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_ZERO_BYPASS_EN
        if (o < 3'd4 && (a == 0 || b == 0)) return 1;
`endif
        return MULDIV_LATENCY;
    endfunction

    // Launch one op, hold start until done, check latency, stall length, result and pulse width.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input int exp_lat, input string tag);
        int k, stalls;
        bit got;
        @(negedge clk);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        #1;
        stalls = stall ? 1 : 0;
        k = 0;
        got = 1'b0;
        while (!got && k < XLEN + 8) begin
            @(negedge clk);
            k++;
            if (done) got = 1'b1;
            else if (stall) stalls++;
        end
        chk({tag, " latency"}, k, exp_lat);
        chk({tag, " result"}, result, exp_res);
        chk({tag, " stall_len"}, stalls, exp_lat);
        chk({tag, " stall_at_done"}, {31'b0, stall}, 32'd0);
        start = 1'b0;
        @(negedge clk);
        chk({tag, " done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, " idle_after"}, {31'b0, busy}, 32'd0);
        chk({tag, " hold"}, result, exp_res);
    endtask

    vec_t vecs[$];

    initial begin
        int n_done;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        vecs.push_back('{MUL,    32'd7,          32'd6,          32'h0000_002A, 33});
        vecs.push_back('{MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 33});
        vecs.push_back('{MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33});
        vecs.push_back('{MULHSU, 32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF, 33});
        vecs.push_back('{MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 33});
        vecs.push_back('{DIV,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD, 33});
        vecs.push_back('{REM,    32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 33});
        vecs.push_back('{DIVU,   32'hFFFF_FFFF,  32'h10,         32'h0FFF_FFFF, 33});
        vecs.push_back('{DIVU,   32'd100,        32'd0,          32'hFFFF_FFFF, 1});
        vecs.push_back('{REMU,   32'd100,        32'd0,          32'd100,       1});
        vecs.push_back('{REM,    32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 1});
        vecs.push_back('{DIV,    32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1});
`ifdef MULDIV_ZERO_BYPASS_EN
        vecs.push_back('{MUL,    32'd0,          32'd5,          32'h0,         1});
`else
        vecs.push_back('{MUL,    32'd0,          32'd5,          32'h0,         33});
`endif

        reset = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; operand_a = '0; operand_b = '0;
        repeat (2) @(negedge clk);
        chk("reset stall", {31'b0, stall}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        chk("reset result", result, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++)
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_res, vecs[i].exp_lat,
                   $sformatf("vec%0d", i));

        // Flush in the 10th CALC cycle aborts silently.
        @(negedge clk);
        start = 1'b1; op = MUL; operand_a = 32'd5; operand_b = 32'd5;
        repeat (10) @(negedge clk);
        chk("flush calc busy", {31'b0, busy}, 32'd1);
        chk("flush calc stall", {31'b0, stall}, 32'd1);
        flush = 1'b1; start = 1'b0;
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush busy", {31'b0, busy}, 32'd0);
        chk("flush stall", {31'b0, stall}, 32'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("flush no_done", n_done, 0);
        run_op(MUL, 32'd3, 32'd3, 32'd9, ref_lat(MUL, 32'd3, 32'd3), "post_flush");

        // Flush beats start in IDLE.
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = MUL; operand_a = 32'd2; operand_b = 32'd2;
        #1;
        chk("idle flush stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        chk("idle flush busy", {31'b0, busy}, 32'd0);
        start = 1'b0; flush = 1'b0;

        // Flush during DONE suppresses the pulse.
        @(negedge clk);
        start = 1'b1; op = DIVU; operand_a = 32'd100; operand_b = 32'd0;
        @(negedge clk);
        flush = 1'b1; start = 1'b0;
        #1;
        chk("done flush done", {31'b0, done}, 32'd0);
        chk("done flush busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        flush = 1'b0;
        chk("done flush idle", {31'b0, busy}, 32'd0);

        run_op(MUL, 32'd3, 32'd3, 32'd9, ref_lat(MUL, 32'd3, 32'd3), "pre_reset");

        // Reset in the middle of a DIVU.
        @(negedge clk);
        start = 1'b1; op = DIVU; operand_a = 32'd1000; operand_b = 32'd7;
        repeat (5) @(negedge clk);
        reset = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("midreset stall", {31'b0, stall}, 32'd0);
        chk("midreset busy", {31'b0, busy}, 32'd0);
        chk("midreset done", {31'b0, done}, 32'd0);
        chk("midreset result", result, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 9))
                0: rb = 32'd0;
                1: ra = 32'd0;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(ro, ra, rb, ref_result(ro, ra, rb), ref_lat(ro, ra, rb),
                   $sformatf("rnd%0d op%0d", i, ro));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the RV32M multiply/divide instructions issued from the execute stage.
- Accepts one operation per start pulse and sequences an iterative datapath: a shift-add multiplier and a restoring divider, sharing one accumulator/shift register pair.
- Drives a stall to the pipeline while busy, then presents a single-cycle result to the EX/MEM boundary alongside alu_data.
- Sits beside the ALU in execute; the forwarding-resolved operands are its inputs.

Parameters:
- XLEN, 32, operand/result width; only 32 is required.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  launch request, sampled only in IDLE
- op  input  3  muldiv_op_type: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- operand_a  input  XLEN  rs1 value, already forwarded
- operand_b  input  XLEN  rs2 value, already forwarded
- flush  input  1  branch/jump squash; aborts any operation in flight
- stall  output  1  hold the pipeline upstream of and including EX
- busy  output  1  FSM not in IDLE
- done  output  1  one-cycle pulse, result valid
- result  output  XLEN  selected product half, quotient or remainder

Behaviour:
- Reset (clk edge with reset=1): FSM to IDLE; counter, accumulator and result cleared to 0; done=0, busy=0, stall=0. Reset mid-operation discards the operation with no done pulse.
- States and transitions:
  - IDLE -> CALC when start=1 and flush=0.
  - IDLE -> DONE directly on a special case (see below).
  - CALC -> DONE when counter reaches XLEN-1.
  - DONE -> IDLE unconditionally.
- Flush:
  - In CALC, flush forces IDLE next cycle, with no done.
  - In DONE, flush forces IDLE and suppresses done.
  - Flush has priority over start.
- Stall: combinational; stall = (state==IDLE & start & ~flush) | (state==CALC). Stall is 0 in DONE, so the pipeline advances with the result that cycle.
- start while busy is ignored. Start must remain high until done; the pipeline guarantees this by stalling.
- Operand conversion at start:
  - Signed operands are converted to magnitude; result sign is captured.
  - MULHSU treats only operand_a as signed.
- Iterations:
  - One bit per cycle; exactly XLEN CALC cycles.
  - start sampled at edge N -> done=1 during cycle N+XLEN+1.
  - Total stall length is XLEN+1 cycles.
- Multiply:
  - 2*XLEN-bit product, negated at the end if the sign is negative.
  - MUL returns the low half; MULH, MULHSU and MULHU return the high half.
- Divide (restoring):
  - Quotient and remainder are computed on magnitudes.
  - Quotient sign = sign_a ^ sign_b.
  - Remainder sign = sign_a.
- Special cases, resolved in IDLE and completing in 1 cycle (done at N+1):
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give operand_a.
  - Signed overflow (operand_a=0x80000000, operand_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- result is registered; it holds its value after done until the next start is accepted.
- All arithmetic wraps modulo 2^XLEN; no overflow flag is produced.

Optional Feature:
- Macro: MULDIV_ZERO_BYPASS_EN.
- Defined: a multiply whose operand_a or operand_b is 0 skips CALC, going IDLE -> DONE with result 0 and done at N+1.
- Undefined: zero operands take the full XLEN+1-cycle path and return 0.
- The divider special cases are always present, with or without the macro.

Decomposition:
- Into common:
  - muldiv_op_type enum (3-bit).
  - muldiv_state_type enum (IDLE, CALC, DONE).
  - Constant MULDIV_LATENCY = XLEN+1.
  - Extended control_type bit is_muldiv, so the decoder can assert start.
- One natural sub-module, muldiv_datapath: accumulator/shift registers and the add/subtract step, steered by the sequencer FSM.

Test Plan:
- MUL 7 × 6 -> stall high for 33 cycles; done pulse at N+33; result 0x0000002A.
- MULH 0xFFFFFFFF × 0xFFFFFFFF (signed -1 × -1) -> result 0x00000000. MULHU on the same operands -> 0xFFFFFFFE.
- DIV 0xFFFFFFF9 / 2 (-7/2) -> 0xFFFFFFFD. REM on the same operands -> 0xFFFFFFFF.
- DIVU 100 / 0 -> done at N+1, result 0xFFFFFFFF. REM 0x80000000 / 0xFFFFFFFF -> done at N+1, result 0.
- Flush asserted in the 10th CALC cycle -> busy=0 and stall=0 next cycle; no done; a new MUL 3 × 3 then returns 9.
- Reset asserted mid-DIVU -> all outputs 0 next cycle. With MULDIV_ZERO_BYPASS_EN, MUL 0 × 5 -> done at N+1, result 0.
